biriscv_trace_serialiser: RTL and testbench

- Sits between the dual-issue writeback/commit stage and the single-stream trace decoder.
- Captures up to two retired instructions per cycle (pc, opcode) in program order.
- Buffers them in a small FIFO and emits one instruction per accepted handshake as a valid/pc/opcode stream.
- Counts instructions dropped on overflow so that trace gaps are detectable.

---
 rtl/biriscv_trace_serialiser_pkg.sv | 21 ++
 rtl/biriscv_trace_serialiser_fifo_mem.sv | 30 +++
 rtl/biriscv_trace_serialiser.sv | 125 ++++++++++++
 tb/tb_biriscv_trace_serialiser.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_trace_serialiser_pkg.sv
// Shared trace-entry layout for the dual-issue trace serialiser.
// An entry packs {pc, opcode} into one 64-bit word.
package biriscv_trace_serialiser_pkg;

  localparam int TRACE_PC_W     = 32;
  localparam int TRACE_OPCODE_W = 32;
  localparam int TRACE_ENTRY_W  = TRACE_PC_W + TRACE_OPCODE_W;

  localparam int TRACE_PC_LSB     = TRACE_OPCODE_W;
  localparam int TRACE_PC_MSB     = TRACE_ENTRY_W - 1;
  localparam int TRACE_OPCODE_LSB = 0;
  localparam int TRACE_OPCODE_MSB = TRACE_OPCODE_W - 1;

  typedef logic [TRACE_ENTRY_W-1:0] trace_entry_t;

  function automatic trace_entry_t pack_entry(input logic [TRACE_PC_W-1:0]     pc,
                                              input logic [TRACE_OPCODE_W-1:0] opcode);
    return {pc, opcode};
  endfunction

endpackage

// File: rtl/biriscv_trace_serialiser_fifo_mem.sv
// Trace FIFO storage: DEPTH x 64 register array with two write ports
// (consecutive addresses) and one asynchronous read port.
module biriscv_trace_fifo_mem
  import biriscv_trace_serialiser_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               we0_i,
  input  logic [DEPTH_W-1:0] waddr0_i,
  input  trace_entry_t       wdata0_i,
  input  logic               we1_i,
  input  logic [DEPTH_W-1:0] waddr1_i,
  input  trace_entry_t       wdata1_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output trace_entry_t       rdata_o
);

  trace_entry_t r_mem [DEPTH];

  // Contents need no reset: the top masks the read data while empty.
  always_ff @(posedge clk_i) begin
    if (we0_i) r_mem[waddr0_i] <= wdata0_i;
    if (we1_i) r_mem[waddr1_i] <= wdata1_i;
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/biriscv_trace_serialiser.sv
// Dual-issue retire trace serialiser: captures up to two retired instructions
// per cycle into a FIFO and emits them one per handshake, counting overflow drops.
module biriscv_trace_serialiser
  import biriscv_trace_serialiser_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int DROP_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               slot0_valid_i,
  input  logic [31:0]        slot0_pc_i,
  input  logic [31:0]        slot0_opcode_i,
  input  logic               slot1_valid_i,
  input  logic [31:0]        slot1_pc_i,
  input  logic [31:0]        slot1_opcode_i,
  output logic               valid_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        opcode_o,
  input  logic               ready_i,
  output logic [DEPTH_W:0]   level_o,
  output logic               overflow_o,
  output logic [DROP_W-1:0]  drop_count_o
);

  if (DEPTH < 4 || (1 << DEPTH_W) != DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 4 and equal 2**DEPTH_W");
  end

  localparam logic [DEPTH_W:0] L_DEPTH = (DEPTH_W+1)'(DEPTH);

  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W:0]   r_count;
  logic               r_overflow;
  logic [DROP_W-1:0]  r_drop_count;

  logic [DEPTH_W:0]   w_free;
  logic [1:0]         w_req;
  logic [1:0]         w_push;
  logic [1:0]         w_drop;
  logic               w_pop;
  logic [DROP_W:0]    w_drop_sum;
  trace_entry_t       w_wdata0;
  trace_entry_t       w_wdata1;
  trace_entry_t       w_rdata;

  assign w_free = L_DEPTH - r_count;
  assign w_req  = {1'b0, slot0_valid_i} + {1'b0, slot1_valid_i};

  // Capacity is judged on the start-of-cycle count; a same-cycle pop frees nothing.
  always_comb begin
    w_push = 2'd0;
    w_drop = 2'd0;
    if (!flush_i) begin
      if (w_free >= (DEPTH_W+1)'(w_req)) begin
        w_push = w_req;
      end else begin
        w_push = w_free[1:0];
        w_drop = w_req - w_free[1:0];
      end
    end
  end

  assign w_pop = (r_count != '0) && ready_i && !flush_i;

  // The first written entry is slot0 when present, otherwise a lone slot1.
  assign w_wdata0 = slot0_valid_i ? pack_entry(slot0_pc_i, slot0_opcode_i)
                                  : pack_entry(slot1_pc_i, slot1_opcode_i);
  assign w_wdata1 = pack_entry(slot1_pc_i, slot1_opcode_i);

  assign w_drop_sum = {1'b0, r_drop_count} + (DROP_W+1)'(w_drop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + DEPTH_W'(w_push);
      r_rd_ptr <= r_rd_ptr + DEPTH_W'(w_pop);
      r_count  <= r_count + (DEPTH_W+1)'(w_push) - (DEPTH_W+1)'(w_pop);
    end
  end

  // Drop statistics survive flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop != 2'd0) begin
      r_overflow   <= 1'b1;
      r_drop_count <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
    end
  end

  biriscv_trace_fifo_mem #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_mem (
    .clk_i    (clk_i),
    .we0_i    (w_push != 2'd0),
    .waddr0_i (r_wr_ptr),
    .wdata0_i (w_wdata0),
    .we1_i    (w_push == 2'd2),
    .waddr1_i (r_wr_ptr + DEPTH_W'(1)),
    .wdata1_i (w_wdata1),
    .raddr_i  (r_rd_ptr),
    .rdata_o  (w_rdata)
  );

  assign valid_o      = (r_count != '0);
  assign pc_o         = valid_o ? w_rdata[TRACE_PC_MSB:TRACE_PC_LSB] : 32'd0;
  assign opcode_o     = valid_o ? w_rdata[TRACE_OPCODE_MSB:TRACE_OPCODE_LSB] : 32'd0;
  assign level_o      = r_count;
  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_biriscv_trace_serialiser.sv
// Scoreboard bench for the trace serialiser: a queue model of the FIFO and
// drop counters, checked every cycle and on every output handshake.
module tb_biriscv_trace_serialiser;

  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op;
  } entry_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        slot0_valid_i = 1'b0;
  logic [31:0] slot0_pc_i = '0;
  logic [31:0] slot0_opcode_i = '0;
  logic        slot1_valid_i = 1'b0;
  logic [31:0] slot1_pc_i = '0;
  logic [31:0] slot1_opcode_i = '0;
  logic        ready_i = 1'b0;

  logic              valid_o, sat_valid_o;
  logic [31:0]       pc_o, opcode_o, sat_pc_o, sat_opcode_o;
  logic [DEPTH_W:0]  level_o, sat_level_o;
  logic              overflow_o, sat_overflow_o;
  logic [15:0]       drop_count_o;
  logic [1:0]        sat_drop_count_o;

  always #5 clk_i = ~clk_i;

  biriscv_trace_serialiser #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .DROP_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .slot0_valid_i(slot0_valid_i), .slot0_pc_i(slot0_pc_i), .slot0_opcode_i(slot0_opcode_i),
    .slot1_valid_i(slot1_valid_i), .slot1_pc_i(slot1_pc_i), .slot1_opcode_i(slot1_opcode_i),
    .valid_o(valid_o), .pc_o(pc_o), .opcode_o(opcode_o), .ready_i(ready_i),
    .level_o(level_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o)
  );

  // Second instance with a 2-bit drop counter sees identical traffic to exercise saturation.
  biriscv_trace_serialiser #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .DROP_W(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .slot0_valid_i(slot0_valid_i), .slot0_pc_i(slot0_pc_i), .slot0_opcode_i(slot0_opcode_i),
    .slot1_valid_i(slot1_valid_i), .slot1_pc_i(slot1_pc_i), .slot1_opcode_i(slot1_opcode_i),
    .valid_o(sat_valid_o), .pc_o(sat_pc_o), .opcode_o(sat_opcode_o), .ready_i(ready_i),
    .level_o(sat_level_o), .overflow_o(sat_overflow_o), .drop_count_o(sat_drop_count_o)
  );

  int checkCount = 0;
  int passCount  = 0;

  entry_t modelQ[$];
  entry_t pendQ[$];
  int     pendDrops = 0;
  bit     pendFlush = 1'b0;
  int     expDrops = 0;
  bit     expOverflow = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  function automatic int satMin(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Drive one cycle of inputs and record what the model says that cycle will store or drop.
  task automatic applyStimulus(input bit v0, input logic [31:0] pc0, input logic [31:0] op0,
                               input bit v1, input logic [31:0] pc1, input logic [31:0] op1,
                               input bit rdy, input bit fl);
    entry_t slots[$];
    int free;
    @(posedge clk_i);
    #1;
    slot0_valid_i = v0; slot0_pc_i = pc0; slot0_opcode_i = op0;
    slot1_valid_i = v1; slot1_pc_i = pc1; slot1_opcode_i = op1;
    ready_i = rdy;
    flush_i = fl;
    pendQ.delete();
    pendDrops = 0;
    pendFlush = fl;
    if (!fl) begin
      if (v0) slots.push_back('{pc: pc0, op: op0});
      if (v1) slots.push_back('{pc: pc1, op: op1});
      free = DEPTH - modelQ.size();
      foreach (slots[i]) begin
        if (i < free) pendQ.push_back(slots[i]);
        else pendDrops++;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] op, input bit rdy);
    applyStimulus(1'b1, pc, op, 1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic pushDual(input logic [31:0] pc0, input logic [31:0] pc1, input bit rdy);
    applyStimulus(1'b1, pc0, 32'h13, 1'b1, pc1, 32'h33, rdy, 1'b0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic applyReset();
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    slot0_valid_i = 1'b0; slot1_valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    modelQ.delete(); pendQ.delete(); pendDrops = 0; pendFlush = 1'b0;
    expDrops = 0; expOverflow = 1'b0;
    #1;
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_level", level_o, 0);
    checkOutput("rst_pc", pc_o, 0);
    checkOutput("rst_opcode", opcode_o, 0);
    checkOutput("rst_overflow", overflow_o, 0);
    checkOutput("rst_drops", drop_count_o, 0);
    checkOutput("rst_sat_drops", sat_drop_count_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  // Commit the pending cycle's effect into the model at the clock edge.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      modelQ.delete();
      expDrops = 0;
      expOverflow = 1'b0;
    end else if (pendFlush) begin
      modelQ.delete();
    end else begin
      foreach (pendQ[i]) modelQ.push_back(pendQ[i]);
      expDrops += pendDrops;
      if (pendDrops > 0) expOverflow = 1'b1;
    end
    pendQ.delete();
    pendDrops = 0;
    pendFlush = 1'b0;
  end

  // Monitor: compare state every cycle, pop the scoreboard on each accepted handshake.
  always @(negedge clk_i) begin
    entry_t head;
    checkOutput("level", level_o, modelQ.size());
    checkOutput("valid", valid_o, modelQ.size() != 0);
    if (modelQ.size() != 0) begin
      head = modelQ[0];
      checkOutput("head_pc", pc_o, head.pc);
      checkOutput("head_opcode", opcode_o, head.op);
    end else begin
      checkOutput("empty_pc", pc_o, 0);
      checkOutput("empty_opcode", opcode_o, 0);
    end
    checkOutput("overflow", overflow_o, expOverflow);
    checkOutput("drop_count", drop_count_o, satMin(expDrops, 65535));
    checkOutput("sat_level", sat_level_o, modelQ.size());
    checkOutput("sat_overflow", sat_overflow_o, expOverflow);
    checkOutput("sat_drop_count", sat_drop_count_o, satMin(expDrops, 3));
    if (rst_i && !flush_i && valid_o && ready_i && modelQ.size() != 0)
      void'(modelQ.pop_front());
  end

  initial begin
    $display("[TB] trace serialiser bench starting");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Single push then pop
    push1(32'h8000_0000, 32'h0000_0013, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Dual push ordering, then drain
    pushDual(32'h100, 32'h104, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // slot1-only push
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'h208, 32'h6f, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill to 7, then overflow with dual pushes
    for (int i = 0; i < 7; i++) push1(32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 1'b0);
    pushDual(32'h300, 32'h304, 1'b0);
    pushDual(32'h308, 32'h30c, 1'b0);
    // Full: simultaneous pop and dual push, both slots dropped
    pushDual(32'h310, 32'h314, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    // Flush at level 5 with a concurrent dual push
    applyStimulus(1'b1, 32'h400, 32'h13, 1'b1, 32'h404, 32'h13, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b0);

    applyReset();

    // Randomised traffic with alternating back-pressure phases
    for (int i = 0; i < 700; i++) begin
      bit v0, v1, rdy, fl;
      int readyPct;
      readyPct = ((i / 80) % 2 == 1) ? 85 : 25;
      v0  = ($urandom_range(0, 2) != 0);
      v1  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 99) < readyPct);
      fl  = ($urandom_range(0, 49) == 0);
      applyStimulus(v0, {$urandom() >> 2, 2'b00}, $urandom(),
                    v1, {$urandom() >> 2, 2'b00}, $urandom(), rdy, fl);
      if (i == 400) applyReset();
    end

    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    @(negedge clk_i);
    #1;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
